mem_stage_pipe: RTL and testbench

MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

---
 rtl/mem_stage_pipe.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_stage_pipe.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_pipe.sv
// Memory pipeline stage: captures one instruction, performs a latency-modelled
// load/store on a word-addressed data memory, and presents the result downstream.
module mem_stage_pipe #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned LAT   = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_wdata,
  input  logic [TAG_W-1:0] in_rd,
  input  logic             in_ld,
  input  logic             in_st,
  input  logic             in_wb,
  input  logic [1:0]       in_size,
  input  logic             in_sext,
  input  logic             fwd_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_alu,
  output logic [31:0]      out_ldresult,
  output logic [TAG_W-1:0] out_rd,
  output logic             out_wb,
  output logic             out_ld,
  output logic             out_fault
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic [31:0]      req_pc_q, req_addr_q, req_wdata_q;
  logic [TAG_W-1:0] req_rd_q;
  logic [1:0]       req_size_q;
  logic             req_sext_q, req_ld_q, req_st_q, req_wb_q;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_pc_q, out_pc_d, out_alu_q, out_alu_d, out_ldr_q, out_ldr_d;
  logic [TAG_W-1:0] out_rd_q, out_rd_d;
  logic             out_wb_q, out_wb_d, out_ld_q, out_ld_d, out_fault_q, out_fault_d;

  logic [31:0] mem_q [DEPTH];

  logic        accept, is_mem, misalign, oob, in_fault, load_imm, complete;
  logic [31:0] st_data, rd_word, byte_sh, ld_val, wr_rep;
  logic [15:0] half_v;
  logic [7:0]  byte_v;
  logic [3:0]  be;
  logic [IDX_W-1:0] req_idx;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mem   = in_ld || in_st;

  always_comb begin
    misalign = 1'b0;
    if (in_size == 2'b01)  misalign = in_addr[0];
    else if (in_size[1])   misalign = |in_addr[1:0];
  end

  assign oob      = {2'b00, in_addr[31:2]} >= DEPTH;
  assign in_fault = is_mem && (misalign || oob);
  assign load_imm = accept && !(is_mem && !in_fault);
  assign complete = (state_q == ACCESS) && (cnt_q == 3'd0);
  assign st_data  = fwd_sel ? out_ldr_q : in_wdata;

  // Load lane selection and extension
  assign req_idx = req_addr_q[IDX_W+1:2];
  assign rd_word = mem_q[req_idx];
  assign byte_sh = rd_word >> {req_addr_q[1:0], 3'b000};
  assign byte_v  = byte_sh[7:0];
  assign half_v  = req_addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    be     = 4'b1111;
    wr_rep = req_wdata_q;
    ld_val = rd_word;
    case (req_size_q)
      2'b00: begin
        be     = 4'b0001 << req_addr_q[1:0];
        wr_rep = {4{req_wdata_q[7:0]}};
        ld_val = req_sext_q ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
      end
      2'b01: begin
        be     = req_addr_q[1] ? 4'b1100 : 4'b0011;
        wr_rep = {2{req_wdata_q[15:0]}};
        ld_val = req_sext_q ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
      end
      default: ;
    endcase
  end

  // Output register is loaded at completion, so DONE is chosen when the
  // downstream cannot take that freshly valid result on the following edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && is_mem && !in_fault) begin
          state_d = ACCESS;
          cnt_d   = 3'(LAT - 1);
        end
      end
      ACCESS: begin
        if (cnt_q == 3'd0) state_d = out_ready ? IDLE : DONE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_alu_d   = out_alu_q;
    out_ldr_d   = out_ldr_q;
    out_rd_d    = out_rd_q;
    out_wb_d    = out_wb_q;
    out_ld_d    = out_ld_q;
    out_fault_d = out_fault_q;
    if (load_imm) begin
      out_valid_d = 1'b1;
      out_pc_d    = in_pc;
      out_alu_d   = in_addr;
      out_ldr_d   = '0;
      out_rd_d    = in_rd;
      out_wb_d    = in_wb && !in_fault;
      out_ld_d    = in_ld;
      out_fault_d = in_fault;
    end else if (complete) begin
      out_valid_d = 1'b1;
      out_pc_d    = req_pc_q;
      out_alu_d   = req_addr_q;
      out_ldr_d   = req_ld_q ? ld_val : '0;
      out_rd_d    = req_rd_q;
      out_wb_d    = req_wb_q;
      out_ld_d    = req_ld_q;
      out_fault_d = 1'b0;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_alu_q   <= '0;
      out_ldr_q   <= '0;
      out_rd_q    <= '0;
      out_wb_q    <= 1'b0;
      out_ld_q    <= 1'b0;
      out_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_alu_q   <= out_alu_d;
      out_ldr_q   <= out_ldr_d;
      out_rd_q    <= out_rd_d;
      out_wb_q    <= out_wb_d;
      out_ld_q    <= out_ld_d;
      out_fault_q <= out_fault_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pc_q    <= '0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_rd_q    <= '0;
      req_size_q  <= '0;
      req_sext_q  <= 1'b0;
      req_ld_q    <= 1'b0;
      req_st_q    <= 1'b0;
      req_wb_q    <= 1'b0;
    end else if (accept) begin
      req_pc_q    <= in_pc;
      req_addr_q  <= in_addr;
      req_wdata_q <= st_data;
      req_rd_q    <= in_rd;
      req_size_q  <= in_size;
      req_sext_q  <= in_sext;
      req_ld_q    <= in_ld;
      req_st_q    <= in_st;
      req_wb_q    <= in_wb;
    end
  end

  // Storage has no reset; the write is gated by state, which reset clears
  always_ff @(posedge clk) begin
    if (complete && req_st_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem_q[req_idx][b*8 +: 8] <= wr_rep[b*8 +: 8];
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = out_pc_q;
  assign out_alu      = out_alu_q;
  assign out_ldresult = out_ldr_q;
  assign out_rd       = out_rd_q;
  assign out_wb       = out_wb_q;
  assign out_ld       = out_ld_q;
  assign out_fault    = out_fault_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Scoreboard bench for mem_stage_pipe: directed ops push expected results,
// a negedge monitor pops and compares on every downstream transfer.
module tb_mem_stage_pipe;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0, in_ready;
  logic [31:0]      in_pc = '0, in_addr = '0, in_wdata = '0;
  logic [TAG_W-1:0] in_rd = '0;
  logic             in_ld = 1'b0, in_st = 1'b0, in_wb = 1'b0;
  logic [1:0]       in_size = '0;
  logic             in_sext = 1'b0, fwd_sel = 1'b0;
  logic             out_valid, out_ready = 1'b1;
  logic [31:0]      out_pc, out_alu, out_ldresult;
  logic [TAG_W-1:0] out_rd;
  logic             out_wb, out_ld, out_fault;

  mem_stage_pipe #(.DEPTH(DEPTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .in_ld(in_ld), .in_st(in_st), .in_wb(in_wb), .in_size(in_size),
    .in_sext(in_sext), .fwd_sel(fwd_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_alu(out_alu), .out_ldresult(out_ldresult),
    .out_rd(out_rd), .out_wb(out_wb), .out_ld(out_ld), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      pc, alu, ldr;
    logic [TAG_W-1:0] rd;
    logic             wb, ld, fault;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got pc 0x%08h expected no transfer", out_pc);
      end else begin
        me = q.pop_front();
        chk("out_pc",       out_pc,                 me.pc);
        chk("out_alu",      out_alu,                me.alu);
        chk("out_ldresult", out_ldresult,           me.ldr);
        chk("out_rd",       32'(out_rd),            32'(me.rd));
        chk("out_wb",       32'(out_wb),            32'(me.wb));
        chk("out_ld",       32'(out_ld),            32'(me.ld));
        chk("out_fault",    32'(out_fault),         32'(me.fault));
      end
    end
  end

  // exp_lat: rising edges after the acceptance edge until out_valid is seen
  task automatic issue(input logic [31:0] pc, addr, wdata, input logic [TAG_W-1:0] rd,
                       input logic ld, st, wb, input logic [1:0] size,
                       input logic sext, fwd, input logic [31:0] exp_ldr,
                       input logic exp_fault, input int exp_lat);
    int k;
    exp_t e;
    @(negedge clk);
    in_pc = pc; in_addr = addr; in_wdata = wdata; in_rd = rd;
    in_ld = ld; in_st = st; in_wb = wb; in_size = size; in_sext = sext;
    fwd_sel = fwd; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("accept_timeout", 32'(k), 32'd0);
    e.pc = pc; e.alu = addr; e.ldr = exp_ldr; e.rd = rd;
    e.wb = wb && !exp_fault; e.ld = ld; e.fault = exp_fault;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_ld = 1'b0; in_st = 1'b0; fwd_sel = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("lat_edges", 32'(k), 32'(exp_lat));
  endtask

  initial begin
    #1 rst = 1'b1;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc",    out_pc,         32'd0);
    chk("rst_out_ldr",   out_ldresult,   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    //     pc           addr         wdata        rd  ld  st  wb  sz     sx  fw  exp_ldr      flt lat
    issue(32'h100, 32'h0000_1234, 32'h0,         4'd3, 0, 0, 1, 2'b10, 0, 0, 32'h0,         0, 0);
    issue(32'h104, 32'h0000_0010, 32'hDEADBEEF, 4'd0, 0, 1, 0, 2'b10, 0, 0, 32'h0,         0, 2);
    issue(32'h108, 32'h0000_0010, 32'h0,         4'd5, 1, 0, 1, 2'b10, 0, 0, 32'hDEADBEEF, 0, 2);
    issue(32'h10C, 32'h0000_0013, 32'h12345680, 4'd0, 0, 1, 0, 2'b00, 0, 0, 32'h0,         0, 2);
    issue(32'h110, 32'h0000_0013, 32'h0,         4'd6, 1, 0, 1, 2'b00, 1, 0, 32'hFFFFFF80, 0, 2);
    issue(32'h114, 32'h0000_0013, 32'h0,         4'd6, 1, 0, 1, 2'b00, 0, 0, 32'h00000080, 0, 2);
    issue(32'h118, 32'h0000_0010, 32'h0,         4'd7, 1, 0, 1, 2'b10, 0, 0, 32'h80ADBEEF, 0, 2);
    issue(32'h11C, 32'h0000_0010, 32'h0,         4'd1, 1, 0, 1, 2'b00, 1, 0, 32'hFFFFFFEF, 0, 2);
    issue(32'h120, 32'h0000_0011, 32'h0,         4'd1, 1, 0, 1, 2'b00, 0, 0, 32'h000000BE, 0, 2);
    issue(32'h124, 32'h0000_0011, 32'h0,         4'd2, 1, 0, 1, 2'b01, 1, 0, 32'h0,         1, 0);
    issue(32'h128, 32'h0000_0012, 32'h0,         4'd2, 1, 0, 1, 2'b01, 1, 0, 32'hFFFF80AD, 0, 2);
    issue(32'h12C, 32'h0000_0012, 32'h0,         4'd2, 1, 0, 1, 2'b01, 0, 0, 32'h000080AD, 0, 2);
    issue(32'h130, 32'h0000_1000, 32'h0,         4'd4, 1, 0, 1, 2'b10, 0, 0, 32'h0,         1, 0);
    issue(32'h134, 32'h0000_1000, 32'h55555555, 4'd0, 0, 1, 0, 2'b10, 0, 0, 32'h0,         1, 0);
    issue(32'h138, 32'h0000_0016, 32'h66666666, 4'd0, 0, 1, 0, 2'b10, 0, 0, 32'h0,         1, 0);
    issue(32'h13C, 32'h0000_0FFC, 32'hCAFEF00D, 4'd0, 0, 1, 0, 2'b10, 0, 0, 32'h0,         0, 2);
    issue(32'h140, 32'h0000_0FFC, 32'h0,         4'd8, 1, 0, 1, 2'b10, 0, 0, 32'hCAFEF00D, 0, 2);
    issue(32'h144, 32'h0000_0012, 32'h00001234, 4'd0, 0, 1, 0, 2'b01, 0, 0, 32'h0,         0, 2);
    issue(32'h148, 32'h0000_0010, 32'h0,         4'd9, 1, 0, 1, 2'b10, 0, 0, 32'h1234BEEF, 0, 2);
    issue(32'h14C, 32'h0000_0030, 32'h0,         4'd0, 0, 1, 0, 2'b10, 0, 1, 32'h0,         0, 2);
    issue(32'h150, 32'h0000_0030, 32'h0,         4'd10, 1, 0, 1, 2'b11, 0, 0, 32'h1234BEEF, 0, 2);

    // Back-pressure across completion
    @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(32'h154, 32'h0000_0010, 32'h0,         4'd11, 1, 0, 1, 2'b10, 0, 0, 32'h1234BEEF, 0, 2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("hold_in_ready",  32'(in_ready),  32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_ldr",   out_ldresult,   32'h1234BEEF);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_in_ready",  32'(in_ready),  32'd1);

    // Reset aborts a store in flight
    issue(32'h158, 32'h0000_0020, 32'h11111111, 4'd0, 0, 1, 0, 2'b10, 0, 0, 32'h0,         0, 2);
    @(negedge clk);
    in_pc = 32'h15C; in_addr = 32'h20; in_wdata = 32'h22222222; in_rd = 4'd12;
    in_ld = 1'b0; in_st = 1'b1; in_wb = 1'b1; in_size = 2'b10; in_valid = 1'b1;
    for (int k = 0; k < 50 && !in_ready; k++) @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0; in_st = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_pc",    out_pc,         32'd0);
    chk("abort_out_alu",   out_alu,        32'd0);
    chk("abort_out_ldr",   out_ldresult,   32'd0);
    chk("abort_out_rd",    32'(out_rd),    32'd0);
    chk("abort_out_flags", {29'd0, out_wb, out_ld, out_fault}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue(32'h160, 32'h0000_0020, 32'h0,         4'd13, 1, 0, 1, 2'b10, 0, 0, 32'h11111111, 0, 2);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
